// File: rtl/cast_pkg.sv
// rtl/cast_pkg.sv - shared cast mode encoding for the width-cast pipeline
package cast_pkg;

  localparam int CAST_MODE_W = 2;

  typedef enum logic [CAST_MODE_W-1:0] {
    CAST_ZEXT = 2'd0,
    CAST_SEXT = 2'd1,
    CAST_FOLD = 2'd2,
    CAST_SAT  = 2'd3
  } cast_mode_e;

endpackage

// File: rtl/cast_unit.sv
// rtl/cast_unit.sv - combinational IN_W to OUT_W cast (zext, sext, fold, signed saturate)
module cast_unit
  import cast_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 24
) (
  input  logic [IN_W-1:0]  i_x,
  input  cast_mode_e       i_mode,
  output logic [OUT_W-1:0] o_result,
  output logic             o_sat
);

  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_fold;
  logic [OUT_W-1:0] w_sat_val;
  logic             w_sat_hit;

  // Size casts zero-fill or sign-fill when widening and keep the low bits when narrowing.
  assign w_zext = OUT_W'(i_x);
  assign w_sext = OUT_W'($signed(i_x));
  // OR and truncation commute, so folding at OUT_W matches folding at the wider width.
  assign w_fold = OUT_W'(i_x) | OUT_W'(i_x >> 1);

  generate
    if (OUT_W >= IN_W) begin : g_widen
      // Every input value is representable, so saturate degenerates to sign-extend.
      assign w_sat_val = w_sext;
      assign w_sat_hit = 1'b0;
    end else begin : g_narrow
      logic w_fits;
      // The value fits when all bits from the new sign position upward agree.
      assign w_fits    = (&i_x[IN_W-1:OUT_W-1]) || !(|i_x[IN_W-1:OUT_W-1]);
      assign w_sat_val = w_fits      ? i_x[OUT_W-1:0] :
                         i_x[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                       {1'b0, {(OUT_W-1){1'b1}}};
      assign w_sat_hit = !w_fits;
    end
  endgenerate

  // Select the result for the requested mode; only SAT can raise the clamp flag.
  always_comb begin
    o_result = w_zext;
    o_sat    = 1'b0;
    case (i_mode)
      CAST_ZEXT: o_result = w_zext;
      CAST_SEXT: o_result = w_sext;
      CAST_FOLD: o_result = w_fold;
      CAST_SAT: begin
        o_result = w_sat_val;
        o_sat    = w_sat_hit;
      end
      default: o_result = w_zext;
    endcase
  end

endmodule

// File: rtl/cast_pipe.sv
// rtl/cast_pipe.sv - two-stage valid/ready width-cast pipeline with saturation counter
module cast_pipe
  import cast_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  input_data,
  input  cast_mode_e       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] output_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] sat_count
);

  logic             r_s1_valid;
  logic [IN_W-1:0]  r_s1_data;
  cast_mode_e       r_s1_mode;
  logic             r_s2_valid;
  logic [OUT_W-1:0] r_s2_data;
  logic             r_s2_sat;
  logic [CNT_W-1:0] r_sat_count;

  logic             w_s2_adv;
  logic             w_in_ready;
  logic             w_out_fire;
  logic [OUT_W-1:0] w_result;
  logic             w_sat;

  // S2 may load when it is empty or its word leaves this cycle; S1 likewise chains on S2.
  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_out_fire = r_s2_valid && out_ready;

  assign in_ready    = w_in_ready;
  assign out_valid   = r_s2_valid;
  assign output_data = r_s2_data;
  assign out_sat     = r_s2_sat;
  assign sat_count   = r_sat_count;

  cast_unit #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_cast (
    .i_x     (r_s1_data),
    .i_mode  (r_s1_mode),
    .o_result(w_result),
    .o_sat   (w_sat)
  );

  // Stage 1 captures the raw word and mode; data only moves on a real accept so stalls hold it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= CAST_ZEXT;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= input_data;
        r_s1_mode <= in_mode;
      end
    end
  end

  // Stage 2 captures the cast result; it holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_sat   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_result;
        r_s2_sat  <= w_sat;
      end
    end
  end

  // Count delivered clamped results, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_count <= '0;
    end else if (w_out_fire && r_s2_sat && (r_sat_count != {CNT_W{1'b1}})) begin
      r_sat_count <= r_sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cast_pipe.sv
// tb/tb_cast_pipe.sv - randomized self-checking bench for cast_pipe against an arithmetic model
module tb_cast_pipe;
  import cast_pkg::*;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
  logic [3:0]  a_input_data;
  cast_mode_e  a_in_mode;
  logic [23:0] a_output_data;
  logic [15:0] a_sat_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
  logic [7:0]  b_input_data;
  cast_mode_e  b_in_mode;
  logic [3:0]  b_output_data;
  logic [1:0]  b_sat_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  longint unsigned a_exp_q[$];
  bit              a_sat_q[$];
  int              a_stamp_q[$];
  longint unsigned b_exp_q[$];
  bit              b_sat_q[$];

  cast_pipe u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .input_data(a_input_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .output_data(a_output_data), .out_sat(a_out_sat), .sat_count(a_sat_count)
  );

  cast_pipe #(.IN_W(8), .OUT_W(4), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .input_data(b_input_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .output_data(b_output_data), .out_sat(b_out_sat), .sat_count(b_sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // Reference cast from plain integer arithmetic on the signed/unsigned value of x.
  function automatic longint unsigned ref_cast(input longint unsigned x, input int m,
                                               input int iw, input int ow, output bit sat);
    longint signed   v, r, lo, hi;
    longint unsigned mask;
    mask = (longint'(1) << ow) - 1;
    v = (x >= (longint'(1) << (iw - 1))) ? longint'(x) - (longint'(1) << iw) : longint'(x);
    sat = 1'b0;
    case (m & 3)
      0: r = longint'(x);
      1: r = v;
      2: r = longint'(x | (x >> 1));
      default: begin
        r = v;
        if (ow < iw) begin
          hi = (longint'(1) << (ow - 1)) - 1;
          lo = -hi - 1;
          if (v > hi) begin r = hi; sat = 1'b1; end
          else if (v < lo) begin r = lo; sat = 1'b1; end
        end
      end
    endcase
    return longint'(r) & mask;
  endfunction

  task automatic step_a(input bit v, input logic [3:0] d, input int m, input bit rdy,
                        output bit acc, output bit ov, output bit emit,
                        output logic [23:0] od, output bit os);
    bit s;
    a_in_valid = v; a_input_data = d; a_in_mode = cast_mode_e'(m[1:0]); a_out_ready = rdy;
    cyc++;
    #1;
    acc = a_in_valid && a_in_ready;
    ov = a_out_valid;
    emit = a_out_valid && a_out_ready;
    od = a_output_data;
    os = a_out_sat;
    if (acc) begin
      a_exp_q.push_back(ref_cast(longint'(d), m, 4, 24, s));
      a_sat_q.push_back(s);
      a_stamp_q.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic step_b(input bit v, input logic [7:0] d, input int m, input bit rdy,
                        output bit acc, output bit ov, output bit emit,
                        output logic [3:0] od, output bit os);
    bit s;
    b_in_valid = v; b_input_data = d; b_in_mode = cast_mode_e'(m[1:0]); b_out_ready = rdy;
    cyc++;
    #1;
    acc = b_in_valid && b_in_ready;
    ov = b_out_valid;
    emit = b_out_valid && b_out_ready;
    od = b_output_data;
    os = b_out_sat;
    if (acc) begin
      b_exp_q.push_back(ref_cast(longint'(d), m, 8, 4, s));
      b_sat_q.push_back(s);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    a_in_valid = 0; a_out_ready = 0; b_in_valid = 0; b_out_ready = 0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_exp_q.delete(); a_sat_q.delete(); a_stamp_q.delete();
    b_exp_q.delete(); b_sat_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
    n_cmp++; if (a_output_data !== 24'h0) begin n_bad++; $display("FAIL reset_a_data: got %h want 0", a_output_data); end
    n_cmp++; if (a_out_sat !== 1'b0) begin n_bad++; $display("FAIL reset_a_sat: got %b want 0", a_out_sat); end
    n_cmp++; if (a_sat_count !== 16'h0) begin n_bad++; $display("FAIL reset_a_count: got %h want 0", a_sat_count); end
    n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
    n_cmp++; if (b_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
    n_cmp++; if (b_sat_count !== 2'h0) begin n_bad++; $display("FAIL reset_b_count: got %h want 0", b_sat_count); end
    @(negedge clk);
  endtask

  task automatic test_modes();
    logic [23:0] k_res[4];
    bit acc, ov, emit, os;
    logic [23:0] od;
    int ne = 0;
    int lat;
    k_res[0] = 24'h00000B; k_res[1] = 24'hFFFFFB; k_res[2] = 24'h00000F; k_res[3] = 24'hFFFFFB;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step_a(i < 4, 4'b1011, i, 1'b1, acc, ov, emit, od, os);
      if (emit && ne < 4) begin
        lat = cyc - a_stamp_q.pop_front();
        void'(a_exp_q.pop_front()); void'(a_sat_q.pop_front());
        n_cmp++; if (od !== k_res[ne] || os !== 1'b0) begin n_bad++; $display("FAIL modes[%0d]: got %h sat %b want %h sat 0", ne, od, os, k_res[ne]); end
        n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL modes_latency[%0d]: got %0d want 2", ne, lat); end
        ne++;
      end
    end
    n_cmp++; if (ne != 4) begin n_bad++; $display("FAIL modes_count: got %0d want 4", ne); end
  endtask

  task automatic test_back_to_back();
    bit acc, ov, emit, os;
    logic [23:0] od;
    longint unsigned e;
    bit es;
    int ne = 0, first = -1, last = -1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step_a(i < 16, 4'($urandom), int'($urandom_range(0, 3)), 1'b1, acc, ov, emit, od, os);
      if (i < 16) begin
        n_cmp++; if (!acc) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got 0 want 1", i); end
      end
      if (emit) begin
        if (a_exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL b2b_extra: got output %h want none", od);
        end else begin
          e = a_exp_q.pop_front(); es = a_sat_q.pop_front();
          n_cmp++; if (od !== e[23:0] || os !== es) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", ne, od, os, e[23:0], es); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        ne++;
      end
    end
    n_cmp++; if (ne != 16 || last - first != 15) begin n_bad++; $display("FAIL b2b_rate: got %0d outputs over %0d cycles want 16 over 16", ne, last - first + 1); end
  endtask

  task automatic test_backpressure();
    logic [3:0] w[3];
    int md[3];
    bit acc, ov, emit, os;
    logic [23:0] od;
    longint unsigned e;
    bit es;
    int k = 0, ne = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin w[i] = 4'($urandom); md[i] = int'($urandom_range(0, 3)); end
    for (int i = 0; i < 3; i++) begin
      step_a(1'b1, w[k], md[k], 1'b0, acc, ov, emit, od, os);
      if (acc) k++;
    end
    n_cmp++; if (k != 2 || acc) begin n_bad++; $display("FAIL bp_accept: got %0d accepted, last ready %b want 2, 0", k, acc); end
    for (int i = 0; i < 3; i++) begin
      step_a(1'b1, w[k], md[k], 1'b0, acc, ov, emit, od, os);
      e = (a_exp_q.size() > 0) ? a_exp_q[0] : 64'hDEAD;
      n_cmp++; if (acc || !ov || od !== e[23:0]) begin n_bad++; $display("FAIL bp_stall[%0d]: got acc %b valid %b data %h want 0 1 %h", i, acc, ov, od, e[23:0]); end
    end
    for (int i = 0; i < 10; i++) begin
      step_a(k < 3, w[k % 3], md[k % 3], 1'b1, acc, ov, emit, od, os);
      if (acc) k++;
      if (emit) begin
        if (a_exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL bp_dup: got extra output %h want none", od);
        end else begin
          e = a_exp_q.pop_front(); es = a_sat_q.pop_front();
          n_cmp++; if (od !== e[23:0] || os !== es) begin n_bad++; $display("FAIL bp_order[%0d]: got %h/%b want %h/%b", ne, od, os, e[23:0], es); end
        end
        ne++;
      end
    end
    n_cmp++; if (ne != 3 || k != 3) begin n_bad++; $display("FAIL bp_total: got %0d out %0d in want 3 3", ne, k); end
  endtask

  task automatic test_sat_narrow();
    logic [7:0] xin[4];
    logic [3:0] k_res[4];
    bit k_sat[4];
    bit acc, ov, emit, os;
    logic [3:0] od;
    int ne = 0;
    xin[0] = 8'h7F; xin[1] = 8'h80; xin[2] = 8'h05; xin[3] = 8'hFD;
    k_res[0] = 4'h7; k_res[1] = 4'h8; k_res[2] = 4'h5; k_res[3] = 4'hD;
    k_sat[0] = 1; k_sat[1] = 1; k_sat[2] = 0; k_sat[3] = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step_b(i < 4, xin[i % 4], 3, 1'b1, acc, ov, emit, od, os);
      if (emit && ne < 4) begin
        n_cmp++; if (od !== k_res[ne] || os !== k_sat[ne]) begin n_bad++; $display("FAIL sat8to4[%0d]: got %h sat %b want %h sat %b", ne, od, os, k_res[ne], k_sat[ne]); end
        ne++;
      end
    end
    #1;
    n_cmp++; if (ne != 4 || b_sat_count !== 2'd2) begin n_bad++; $display("FAIL sat8to4_count: got %0d outputs count %0d want 4 count 2", ne, b_sat_count); end
    @(negedge clk);
  endtask

  task automatic test_cnt_saturate();
    bit acc, ov, emit, os, sent, got;
    logic [3:0] od;
    int want;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sent = 0; got = 0;
      for (int j = 0; j < 8 && !got; j++) begin
        step_b(!sent, 8'h7F, 3, 1'b1, acc, ov, emit, od, os);
        if (acc) sent = 1;
        if (emit) got = 1;
      end
      want = (k + 1 > 3) ? 3 : k + 1;
      #1;
      n_cmp++; if (!got || b_sat_count !== 2'(want)) begin n_bad++; $display("FAIL cnt_sticky[%0d]: got count %0d delivered %b want %0d 1", k, b_sat_count, got, want); end
      @(negedge clk);
    end
  endtask

  task automatic test_random_narrow();
    bit acc, ov, emit, os, rdy, p_ov, p_rdy;
    logic [3:0] od, p_od;
    longint unsigned e;
    bit es;
    int nsat = 0;
    do_reset();
    p_ov = 0; p_rdy = 1; p_od = 0;
    for (int i = 0; i < 80; i++) begin
      rdy = (i >= 70) ? 1'b1 : 1'($urandom_range(0, 1));
      step_b((i < 70) && ($urandom_range(0, 3) != 0), 8'($urandom), int'($urandom_range(0, 3)), rdy,
             acc, ov, emit, od, os);
      if (p_ov && !p_rdy) begin
        n_cmp++; if (!ov || od !== p_od) begin n_bad++; $display("FAIL rnd_hold[%0d]: got %b/%h want 1/%h", i, ov, od, p_od); end
      end
      if (emit) begin
        if (b_exp_q.size() == 0) begin
          n_cmp++; n_bad++; $display("FAIL rnd_extra[%0d]: got %h want none", i, od);
        end else begin
          e = b_exp_q.pop_front(); es = b_sat_q.pop_front();
          if (es) nsat++;
          n_cmp++; if (od !== e[3:0] || os !== es) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", i, od, os, e[3:0], es); end
        end
      end
      p_ov = ov; p_rdy = rdy; p_od = od;
    end
    #1;
    n_cmp++; if (b_exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d left want 0", b_exp_q.size()); end
    n_cmp++; if (b_sat_count !== 2'((nsat > 3) ? 3 : nsat)) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", b_sat_count, (nsat > 3) ? 3 : nsat); end
    @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    bit acc, ov, emit, os;
    logic [23:0] od;
    do_reset();
    step_a(1'b1, 4'h9, 1, 1'b0, acc, ov, emit, od, os);
    step_a(1'b1, 4'h6, 2, 1'b0, acc, ov, emit, od, os);
    step_a(1'b1, 4'h3, 0, 1'b0, acc, ov, emit, od, os);
    n_cmp++; if (acc || !ov) begin n_bad++; $display("FAIL midrst_full: got acc %b valid %b want 0 1", acc, ov); end
    rst = 1'b1;
    step_a(1'b0, 4'h0, 0, 1'b0, acc, ov, emit, od, os);
    rst = 1'b0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b0 || a_sat_count !== 16'h0 || a_in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midrst_state: got valid %b count %h ready %b want 0 0 1", a_out_valid, a_sat_count, a_in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b0, 4'h0, 0, 1'b1, acc, ov, emit, od, os);
      n_cmp++; if (ov) begin n_bad++; $display("FAIL midrst_stale[%0d]: got valid 1 data %h want 0", i, od); end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_input_data = 0; a_in_mode = CAST_ZEXT; a_out_ready = 0;
    b_in_valid = 0; b_input_data = 0; b_in_mode = CAST_ZEXT; b_out_ready = 0;
    @(negedge clk);
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_sat_narrow();
    test_cnt_saturate();
    test_random_narrow();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
